// File: rtl/core_pipeline_ctrl.sv
// Pipeline hazard and trap controller: arbitrates EX-stage redirects, memory
// stalls, WFI sleep and trap entry, and produces stall/flush/PC-load controls.
module core_pipeline_ctrl #(
    parameter int unsigned PC_LEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [PC_LEN-1:0] ex_pc,
    input  logic [PC_LEN-1:0] ex_next_pc,
    input  logic              jump_en_ex,
    input  logic [PC_LEN-1:0] jump_addr_ex,
    input  logic              wfi,
    input  logic              mem_req,
    input  logic              mem_busy,
    input  logic              exc_req,
    input  logic [3:0]        exc_cause,
    input  logic              irq_pending,
    input  logic              irq_wake,
    input  logic [4:0]        irq_cause,
    input  logic [PC_LEN-1:0] mtvec,
    output logic              pc_load,
    output logic [PC_LEN-1:0] pc_load_addr,
    output logic              stall_if,
    output logic              stall_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              ex_kill,
    output logic              trap_enter,
    output logic [PC_LEN-1:0] trap_mepc,
    output logic [31:0]       trap_mcause,
    output logic              sleeping
);

    typedef enum logic [1:0] {StRun, StMemWait, StSleep, StTrap} state_e;

    state_e            state_q, state_d;
    logic [PC_LEN-1:0] mepc_q, mepc_d;
    logic [31:0]       mcause_q, mcause_d;

    // RUN-state request decode in priority order; a misaligned jump beats an interrupt
    logic jump_misaligned;
    logic run_trap, run_mem, run_jump, run_wfi;
    logic [31:0] irq_mcause;

    assign jump_misaligned = jump_en_ex & jump_addr_ex[1];
    assign run_trap   = ex_valid & (exc_req | jump_misaligned | irq_pending);
    assign run_mem    = ex_valid & ~run_trap & mem_req & mem_busy;
    assign run_jump   = ex_valid & ~run_trap & ~run_mem & jump_en_ex;
    assign run_wfi    = ex_valid & ~run_trap & ~run_mem & ~jump_en_ex & wfi;
    assign irq_mcause = {1'b1, 26'b0, irq_cause};

    // Vector offset is only applied to interrupts in vectored mode
    logic [PC_LEN-1:0] trap_base, trap_off;
    assign trap_base = {mtvec[PC_LEN-1:2], 2'b00};
    assign trap_off  = (mtvec[1:0] == 2'd1 && mcause_q[31]) ?
                       {{(PC_LEN-7){1'b0}}, mcause_q[4:0], 2'b00} : '0;

    // State and captured trap CSR values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    // Next state and trap value capture
    always_comb begin
        state_d  = state_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        unique case (state_q)
            StRun: begin
                if (run_trap) begin
                    state_d = StTrap;
                    mepc_d  = ex_pc;
                    if (exc_req)              mcause_d = {28'b0, exc_cause};
                    else if (jump_misaligned) mcause_d = 32'd0;
                    else                      mcause_d = irq_mcause;
                end else if (run_mem) begin
                    state_d = StMemWait;
                end else if (run_wfi) begin
                    state_d = StSleep;
                    mepc_d  = ex_next_pc;
                end
            end
            StMemWait: begin
                if (!mem_busy) state_d = StRun;
            end
            StSleep: begin
                if (irq_wake) begin
                    if (irq_pending) begin
                        state_d  = StTrap;
                        mcause_d = irq_mcause;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StTrap: begin
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // Pipeline control outputs for the current state
    always_comb begin
        pc_load      = 1'b0;
        pc_load_addr = '0;
        stall_if     = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        ex_kill      = 1'b0;
        trap_enter   = 1'b0;
        sleeping     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (run_trap) begin
                    ex_kill     = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (run_mem) begin
                    stall_if    = 1'b1;
                    stall_id_ex = 1'b1;
                end else if (run_jump) begin
                    pc_load      = 1'b1;
                    pc_load_addr = jump_addr_ex;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                end else if (run_wfi) begin
                    flush_id_ex = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_busy) begin
                    stall_if    = 1'b1;
                    stall_id_ex = 1'b1;
                end else if (ex_valid && jump_en_ex && !jump_addr_ex[1]) begin
                    pc_load      = 1'b1;
                    pc_load_addr = jump_addr_ex;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                end
            end
            StSleep: begin
                sleeping    = 1'b1;
                stall_if    = 1'b1;
                flush_id_ex = 1'b1;
                if (irq_wake && !irq_pending) begin
                    pc_load      = 1'b1;
                    pc_load_addr = mepc_q;
                end
            end
            StTrap: begin
                trap_enter   = 1'b1;
                pc_load      = 1'b1;
                pc_load_addr = trap_base + trap_off;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end
            default: ;
        endcase
    end

    assign trap_mepc   = mepc_q;
    assign trap_mcause = mcause_q;

endmodule

// File: doc/core_pipeline_ctrl.md
CORE_PIPELINE_CTRL -- requirements
Module: core_pipeline_ctrl

Interface
REQ-001 SHALL have parameter PC_LEN, default 32: width of PC, jump and trap addresses.
REQ-002 SHALL have port clk, input, 1: single core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port ex_valid, input, 1: the EX stage holds a real (non-bubble) instruction.
REQ-005 SHALL have port ex_pc, input, PC_LEN: address of the EX instruction.
REQ-006 SHALL have port ex_next_pc, input, PC_LEN: address following the EX instruction.
REQ-007 SHALL have port jump_en_ex / jump_addr_ex, input, 1 / PC_LEN: EX redirect request and target.
REQ-008 SHALL have port wfi, input, 1: EX holds a WFI.
REQ-009 SHALL have port mem_req / mem_busy, input, 1 / 1: EX issues a load/store; bus not ready.
REQ-010 SHALL have port exc_req / exc_cause, input, 1 / 4: synchronous exception from EX (ecall, ebreak, illegal) and its code.
REQ-011 SHALL have port irq_pending / irq_wake / irq_cause, input, 1 / 1 / 5: interrupt enabled and pending (already masked by MIE); any interrupt pending (unmasked); interrupt code.
REQ-012 SHALL have port mtvec, input, PC_LEN: trap vector; bits [1:0] select mode (0 direct, 1 vectored).
REQ-013 SHALL have port pc_load / pc_load_addr, output, 1 / PC_LEN: force PC to address.
REQ-014 SHALL have port stall_if / stall_id_ex, output, 1 / 1: hold PC+IF/ID; hold ID/EX.
REQ-015 SHALL have port flush_if_id / flush_id_ex, output, 1 / 1: bubble the pipeline register on the next edge.
REQ-016 SHALL have port ex_kill, output, 1: suppress register, CSR and store writes of the EX instruction.
REQ-017 SHALL have port trap_enter / trap_mepc / trap_mcause, output, 1 / PC_LEN / 32: CSR trap update strobe and values.
REQ-018 SHALL have port sleeping, output, 1: core in WFI sleep.

Function
REQ-019 SHALL implement FSM states RUN, MEM_WAIT, SLEEP, TRAP.
REQ-020 In RUN with ex_valid, SHALL prioritise exception > misaligned jump > interrupt > mem stall > jump > wfi.
REQ-021 exc_req: same cycle ex_kill=1, flush_if_id=1, flush_id_ex=1; capture mepc=ex_pc, mcause={1'b0,27'b0,exc_cause}; next state TRAP.
REQ-022 jump_en_ex with jump_addr_ex[1]=1: treat as exception, mcause=0 (instruction address misaligned), mepc=ex_pc.
REQ-023 irq_pending: same as REQ-021 except mepc=ex_pc, mcause={1'b1,26'b0,irq_cause}.
REQ-024 mem_req&&mem_busy: stall_if=1, stall_id_ex=1, flush_id_ex=0; next state MEM_WAIT.
REQ-025 MEM_WAIT: hold stalls while mem_busy=1; when mem_busy=0, release stalls the same cycle, apply any jump_en_ex per REQ-026, return to RUN.
REQ-026 jump_en_ex (aligned): same cycle pc_load=1, pc_load_addr=jump_addr_ex, flush_if_id=1, flush_id_ex=1; stay RUN.
REQ-027 wfi: EX completes (no kill); capture mepc=ex_next_pc; flush_id_ex=1; next state SLEEP.
REQ-028 SLEEP: sleeping=1, stall_if=1, flush_id_ex=1 every cycle; on irq_wake=0 stay; on irq_pending=1 set mcause per REQ-023 (mepc kept = captured ex_next_pc), go TRAP; on irq_wake=1 && irq_pending=0, pc_load=1 with captured mepc, go RUN.
REQ-029 TRAP (exactly one cycle): trap_enter=1, pc_load=1, flush_if_id=1, flush_id_ex=1; pc_load_addr={mtvec[PC_LEN-1:2],2'b00}, plus 4*mcause[4:0] if mtvec[1:0]=1 and mcause[31]=1; next RUN.
REQ-030 trap_mepc/trap_mcause SHALL be registered and stable from capture until the next capture.
REQ-031 Trap entry latency: detection at cycle N, pc_load at mtvec in cycle N+1, first handler fetch N+2.
REQ-032 ex_valid=0 SHALL ignore all EX-sourced requests; irq in RUN with ex_valid=0 SHALL wait for a valid instruction.
REQ-033 All address arithmetic SHALL be PC_LEN-bit modulo 2^PC_LEN.

Reset
REQ-034 On rst=1 at a clock edge: state=RUN; all 1-bit outputs 0; pc_load_addr, trap_mepc, trap_mcause 0; this applies from any state including SLEEP, MEM_WAIT and TRAP.

Verification
REQ-035 ex_pc=0x100, jump_en_ex=1, jump_addr_ex=0x200 -> same cycle pc_load=1, addr 0x200, both flushes 1.
REQ-036 ex_pc=0x40, exc_req=1, exc_cause=11, mtvec=0x80 -> ex_kill; next cycle trap_enter=1, pc_load_addr=0x80, mepc=0x40, mcause=0x0000000B.
REQ-037 mtvec=0x81, irq_pending=1, irq_cause=7, ex_pc=0x10 -> TRAP addr 0x9C, mcause=0x80000007, mepc=0x10.
REQ-038 wfi at ex_next_pc=0x24, 5 idle cycles, then irq_pending=irq_wake=1, cause 11 -> sleeping=1 for those cycles, then trap with mepc=0x24, addr=mtvec base.
REQ-039 mem_req=1, mem_busy=1 for 3 cycles with jump_en_ex=1 -> stalls held 3 cycles, no pc_load until mem_busy=0, then pc_load that cycle.
REQ-040 rst asserted during SLEEP -> next cycle sleeping=0, state RUN, all outputs 0.
